// File: rtl/cpu_boot_loader_if.sv
// Stream and memory-port bundle for cpu_boot_loader.
//   s_valid/s_ready/s_data      : command/data word stream into the loader
//   addr_ext..rdata_ext         : instruction-memory external port
//   addr_ext_2..rdata_ext_2     : data-memory external port
// Modports: master = loader side, slave = environment (stream source + memories).
interface cpu_boot_loader_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;

  logic [31:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [31:0] rdata_ext;

  logic [31:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [31:0] wdata_ext_2;
  logic [31:0] rdata_ext_2;

  modport master (
    input  s_valid, s_data, rdata_ext, rdata_ext_2,
    output s_ready, addr_ext, wen_ext, ren_ext, wdata_ext,
    output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );

  modport slave (
    output s_valid, s_data, rdata_ext, rdata_ext_2,
    input  s_ready, addr_ext, wen_ext, ren_ext, wdata_ext,
    input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );
endinterface

// File: rtl/cpu_boot_loader.sv
// Boot/program-load controller in front of the cpu top. Takes header/base/data words
// from a valid/ready stream, writes IMEM or DMEM through the external memory ports
// and drives cpu_enable for run/halt. All outputs are registered.
// Ports:
//   clk, arst   : clock, asynchronous active-high reset
//   bus         : cpu_boot_loader_if.master (stream in, both memory ports out)
//   cpu_enable  : drives cpu.enable
//   busy        : high outside IDLE and RUN
//   error       : sticky error, cleared only by arst
// Optional feature macro: CPU_BOOT_LOADER_READBACK_EN (read back and compare each
// written word; mismatch goes to ERROR).
module cpu_boot_loader #(
  parameter int unsigned IMEM_DEPTH = 512,
  parameter int unsigned DMEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              arst,
  cpu_boot_loader_if.master bus,
  output logic              cpu_enable,
  output logic              busy,
  output logic              error
);

`ifdef CPU_BOOT_LOADER_READBACK_EN
  typedef enum logic [2:0] {StIdle, StAddr, StData, StRun, StError, StVerify1, StVerify2} state_e;
`else
  typedef enum logic [2:0] {StIdle, StAddr, StData, StRun, StError} state_e;
`endif

  localparam logic [16:0] ImemDepth = 17'(IMEM_DEPTH);
  localparam logic [16:0] DmemDepth = 17'(DMEM_DEPTH);

  state_e      state_q, state_d;
  logic        tgt_dmem_q;
  logic [15:0] remain_q;
  logic [16:0] idx_q;

  logic        s_ready_q;
  logic [31:0] addr_q, wdata_q, addr2_q, wdata2_q;
  logic        wen_q, wen2_q;
  logic        cpu_enable_q, busy_q, error_q;

  logic        hs;
  logic [1:0]  cmd;
  logic [15:0] hdr_n;
  logic [16:0] depth, end_idx;
  logic        range_bad;

  assign hs      = bus.s_valid & s_ready_q;
  assign cmd     = bus.s_data[31:30];
  assign hdr_n   = bus.s_data[15:0];
  assign depth   = tgt_dmem_q ? DmemDepth : ImemDepth;
  // 17-bit sum cannot wrap; a base with bits above 15 set can never fit either memory.
  assign end_idx   = {1'b0, bus.s_data[15:0]} + {1'b0, remain_q};
  assign range_bad = (|bus.s_data[31:16]) | (end_idx > depth);

`ifdef CPU_BOOT_LOADER_READBACK_EN
  logic        ren_q, ren2_q;
  logic        rb_mismatch;
  assign rb_mismatch = tgt_dmem_q ? (bus.rdata_ext_2 != wdata2_q) : (bus.rdata_ext != wdata_q);
  assign bus.ren_ext   = ren_q;
  assign bus.ren_ext_2 = ren2_q;
`else
  logic unused_rdata;
  assign unused_rdata  = ^{bus.rdata_ext, bus.rdata_ext_2};
  assign bus.ren_ext   = 1'b0;
  assign bus.ren_ext_2 = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (hs) begin
          if (!cmd[1] && (hdr_n != 16'd0)) state_d = StAddr;
          else if (cmd == 2'b11)           state_d = StRun;
        end
      end
      StAddr: if (hs) state_d = range_bad ? StError : StData;
      StData: begin
        if (hs) begin
`ifdef CPU_BOOT_LOADER_READBACK_EN
          state_d = StVerify1;
`else
          if (remain_q == 16'd1) state_d = StIdle;
`endif
        end
      end
`ifdef CPU_BOOT_LOADER_READBACK_EN
      StVerify1: state_d = StVerify2;
      // remain_q was already decremented at the data handshake
      StVerify2: state_d = rb_mismatch ? StError : ((remain_q == 16'd0) ? StIdle : StData);
`endif
      StRun: begin
        if (hs) begin
          if (!cmd[1])           state_d = StError;
          else if (cmd == 2'b10) state_d = StIdle;
        end
      end
      StError: state_d = StError;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= StIdle;
      tgt_dmem_q   <= 1'b0;
      remain_q     <= 16'd0;
      idx_q        <= 17'd0;
      s_ready_q    <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wen_q        <= 1'b0;
      addr2_q      <= 32'd0;
      wdata2_q     <= 32'd0;
      wen2_q       <= 1'b0;
      cpu_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef CPU_BOOT_LOADER_READBACK_EN
      ren_q        <= 1'b0;
      ren2_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cpu_enable_q <= (state_d == StRun);
      busy_q       <= (state_d != StIdle) && (state_d != StRun);
      error_q      <= (state_d == StError);
      wen_q        <= 1'b0;
      wen2_q       <= 1'b0;
`ifdef CPU_BOOT_LOADER_READBACK_EN
      s_ready_q    <= (state_d != StVerify1) && (state_d != StVerify2);
      ren_q        <= 1'b0;
      ren2_q       <= 1'b0;
`else
      s_ready_q    <= 1'b1;
`endif
      case (state_q)
        StIdle: begin
          if (hs && !cmd[1] && (hdr_n != 16'd0)) begin
            tgt_dmem_q <= cmd[0];
            remain_q   <= hdr_n;
          end
        end
        StAddr: if (hs) idx_q <= {1'b0, bus.s_data[15:0]};
        StData: begin
          if (hs) begin
            if (tgt_dmem_q) begin
              addr2_q  <= {15'd0, idx_q};
              wdata2_q <= bus.s_data;
              wen2_q   <= 1'b1;
            end else begin
              addr_q  <= {15'd0, idx_q};
              wdata_q <= bus.s_data;
              wen_q   <= 1'b1;
            end
            idx_q    <= idx_q + 17'd1;
            remain_q <= remain_q - 16'd1;
          end
        end
`ifdef CPU_BOOT_LOADER_READBACK_EN
        // Address register still holds the index just written.
        StVerify1: begin
          if (tgt_dmem_q) ren2_q <= 1'b1;
          else            ren_q  <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.s_ready     = s_ready_q;
  assign bus.addr_ext    = addr_q;
  assign bus.wen_ext     = wen_q;
  assign bus.wdata_ext   = wdata_q;
  assign bus.addr_ext_2  = addr2_q;
  assign bus.wen_ext_2   = wen2_q;
  assign bus.wdata_ext_2 = wdata2_q;
  assign cpu_enable      = cpu_enable_q;
  assign busy            = busy_q;
  assign error           = error_q;

endmodule
